// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared store/load select codes, byte-enable constants and store buffer entry type
package mips_mem_pkg;

  localparam logic [1:0] ST_SW = 2'd0;
  localparam logic [1:0] ST_SH = 2'd1;
  localparam logic [1:0] ST_SB = 2'd2;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Load-side select codes, kept here so both extraction and insertion agree
  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - replicates store data into word lanes and derives byte enables and misalignment
module store_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_sel,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misalign
);

  // Reserved select code falls through to the word path
  always_comb begin
    wdata    = st_data;
    be       = BE_WORD;
    misalign = 1'b0;
    case (st_sel)
      ST_SB: begin
        wdata = {4{st_data[7:0]}};
        be    = BE_BYTE0 << st_addr[1:0];
      end
      ST_SH: begin
        wdata    = {2{st_data[15:0]}};
        be       = st_addr[1] ? BE_HALF_HI : BE_HALF_LO;
        misalign = st_addr[0];
      end
      default: misalign = (st_addr[1:0] != 2'b00);
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO draining to data memory over req/gnt; STORE_FORWARD_EN adds load forwarding
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [31:0]            st_addr,
  input  logic [31:0]            st_data,
  input  logic [1:0]             st_sel,
  output logic                   st_misalign,
  output logic                   mem_req,
  input  logic                   mem_gnt,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_be,
  output logic [$clog2(DEPTH):0] count,
  input  logic [31:0]            fwd_addr,
  output logic [3:0]             fwd_be,
  output logic [31:0]            fwd_data
);

  localparam int AW = $clog2(DEPTH);

  sb_entry_t        entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [31:0]      al_wdata;
  logic [3:0]       al_be;
  logic             al_misalign;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  store_align u_align (
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_sel   (st_sel),
    .wdata    (al_wdata),
    .be       (al_be),
    .misalign (al_misalign)
  );

  assign full        = (count == (AW + 1)'(DEPTH));
  assign empty       = (count == '0);
  assign st_ready    = !full;
  assign st_misalign = st_valid & al_misalign;
  assign push        = st_valid & !full & !al_misalign;
  assign pop         = !empty & mem_gnt;

  assign mem_req   = !empty;
  assign mem_addr  = empty ? 32'h0 : {entry_q[rd_ptr].waddr, 2'b00};
  assign mem_wdata = empty ? 32'h0 : entry_q[rd_ptr].wdata;
  assign mem_be    = empty ? BE_NONE : entry_q[rd_ptr].be;

  // push and pop never target the same slot: push needs !full, pop needs !empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      if (push) begin
        entry_q[wr_ptr] <= '{waddr: st_addr[31:2], wdata: al_wdata, be: al_be};
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + AW'(1);
      end
      if (push && !pop)      count <= count + (AW + 1)'(1);
      else if (pop && !push) count <= count - (AW + 1)'(1);
    end
  end

`ifdef STORE_FORWARD_EN
  logic [AW-1:0] idx;

  // Walk oldest to youngest so younger entries overwrite older lanes
  always_comb begin
    fwd_be   = BE_NONE;
    fwd_data = 32'h0;
    idx      = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (valid_q[idx] && entry_q[idx].waddr == fwd_addr[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (entry_q[idx].be[b]) begin
            fwd_be[b]         = 1'b1;
            fwd_data[8*b +: 8] = entry_q[idx].wdata[8*b +: 8];
          end
        end
      end
    end
  end
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^fwd_addr;
  assign fwd_be          = BE_NONE;
  assign fwd_data        = 32'h0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed bench with queue model for store_buffer; honours STORE_FORWARD_EN
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_sel = '0;
  logic        st_misalign;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [2:0]  count;
  logic [31:0] fwd_addr = '0;
  logic [3:0]  fwd_be;
  logic [31:0] fwd_data;

  int n_checks = 0;
  int n_fail = 0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_sel(st_sel), .st_misalign(st_misalign),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .count(count), .fwd_addr(fwd_addr), .fwd_be(fwd_be), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_mis(input logic [31:0] a, input logic [1:0] sel);
    if (sel == 2'd2) return 1'b0;
    if (sel == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic ent_t model_ent(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sel);
    ent_t e;
    e.addr = (a / 4) * 4;
    if (sel == 2'd2) begin
      e.wdata = (d & 32'hFF) * 32'h01010101;
      e.be    = 4'(1 << (a % 4));
    end else if (sel == 2'd1) begin
      e.wdata = (d & 32'hFFFF) * 32'h00010001;
      e.be    = ((a % 4) >= 2) ? 4'd12 : 4'd3;
    end else begin
      e.wdata = d;
      e.be    = 4'd15;
    end
    return e;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) q.delete();
    else begin
      bit do_pop;
      bit do_push;
      do_pop  = (q.size() > 0) && mem_gnt;
      do_push = st_valid && (q.size() < DEPTH) && !model_mis(st_addr, st_sel);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(model_ent(st_addr, st_data, st_sel));
    end
  end

  always @(negedge clk) begin
    logic [3:0]  e_fbe;
    logic [31:0] e_fdata;
    e_fbe   = 4'd0;
    e_fdata = 32'd0;
`ifdef STORE_FORWARD_EN
    foreach (q[i]) begin
      if ((q[i].addr / 4) == (fwd_addr / 4)) begin
        for (int b = 0; b < 4; b++) begin
          if (q[i].be[b]) begin
            e_fbe[b] = 1'b1;
            e_fdata  = (e_fdata & ~(32'hFF << (8 * b))) | (q[i].wdata & (32'hFF << (8 * b)));
          end
        end
      end
    end
`endif
    check("m_count", 32'(count), 32'(q.size()));
    check("m_st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
    check("m_st_misalign", 32'(st_misalign), 32'(st_valid && model_mis(st_addr, st_sel)));
    check("m_mem_req", 32'(mem_req), 32'(q.size() > 0));
    check("m_mem_addr", mem_addr, (q.size() > 0) ? q[0].addr : 32'h0);
    check("m_mem_wdata", mem_wdata, (q.size() > 0) ? q[0].wdata : 32'h0);
    check("m_mem_be", 32'(mem_be), (q.size() > 0) ? 32'(q[0].be) : 32'h0);
    check("m_fwd_be", 32'(fwd_be), 32'(e_fbe));
    check("m_fwd_data", fwd_data, e_fdata);
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sel);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_sel   = sel;
  endtask

  logic [31:0] t3_addr [4] = '{32'h100, 32'h106, 32'h109, 32'h10C};
  logic [31:0] t3_data [4] = '{32'hCAFEF00D, 32'h0000BEEF, 32'h0000005A, 32'h01234567};
  logic [1:0]  t3_sel  [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [31:0] t3_xaddr[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
  logic [31:0] t3_xwd  [4] = '{32'hCAFEF00D, 32'hBEEFBEEF, 32'h5A5A5A5A, 32'h01234567};
  logic [3:0]  t3_xbe  [4] = '{4'hF, 4'hC, 4'h2, 4'hF};

  initial begin
    step();
    step();
    check("reset_count", 32'(count), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    reset = 1'b1;
    step();

    // sb to byte lane 3
    drive(32'h13, 32'hAB, 2'd2);
    step();
    st_valid = 1'b0;
    check("sb_req", 32'(mem_req), 32'd1);
    check("sb_addr", mem_addr, 32'h10);
    check("sb_be", 32'(mem_be), 32'h8);
    check("sb_wdata", mem_wdata, 32'hABABABAB);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("sb_drained", 32'(count), 32'd0);

    // sh upper half, then misaligned sh
    drive(32'h22, 32'h1234, 2'd1);
    step();
    st_valid = 1'b0;
    check("sh_be", 32'(mem_be), 32'hC);
    check("sh_wdata", mem_wdata, 32'h12341234);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    drive(32'h21, 32'h5678, 2'd1);
    #1;
    check("sh_misalign", 32'(st_misalign), 32'd1);
    step();
    st_valid = 1'b0;
    check("sh_mis_count", 32'(count), 32'd0);
    check("sh_mis_req", 32'(mem_req), 32'd0);

    // fill to DEPTH with gnt low
    for (int i = 0; i < 4; i++) begin
      drive(t3_addr[i], t3_data[i], t3_sel[i]);
      step();
    end
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(st_ready), 32'd0);
    check("full_head", mem_addr, 32'h100);
    // push at full with simultaneous pop must be dropped
    drive(32'h110, 32'h77, 2'd2);
    mem_gnt = 1'b1;
    step();
    st_valid = 1'b0;
    check("full_pop_count", 32'(count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      check("drain_addr", mem_addr, t3_xaddr[i]);
      check("drain_wdata", mem_wdata, t3_xwd[i]);
      check("drain_be", 32'(mem_be), 32'(t3_xbe[i]));
      step();
    end
    mem_gnt = 1'b0;
    check("drain_req_off", 32'(mem_req), 32'd0);
    check("drain_addr_zero", mem_addr, 32'd0);

    // push+pop at count=2, then async reset at count=3
    drive(32'h200, 32'h1, 2'd0);
    step();
    drive(32'h204, 32'h2, 2'd0);
    step();
    drive(32'h208, 32'h3, 2'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("pp_count", 32'(count), 32'd2);
    check("pp_head", mem_addr, 32'h204);
    drive(32'h20C, 32'h4, 2'd0);
    step();
    st_valid = 1'b0;
    check("pre_reset_count", 32'(count), 32'd3);
    reset = 1'b0;
    #1;
    check("async_reset_count", 32'(count), 32'd0);
    check("async_reset_req", 32'(mem_req), 32'd0);
    step();
    reset = 1'b1;
    step();
    check("post_reset_req", 32'(mem_req), 32'd0);

    // forwarding: word then younger byte overlay
    drive(32'h40, 32'h11223344, 2'd0);
    step();
    drive(32'h41, 32'hEE, 2'd2);
    step();
    st_valid = 1'b0;
    fwd_addr = 32'h40;
    #1;
`ifdef STORE_FORWARD_EN
    check("fwd_be", 32'(fwd_be), 32'hF);
    check("fwd_data", fwd_data, 32'h1122EE44);
`else
    check("fwd_be_off", 32'(fwd_be), 32'h0);
    check("fwd_data_off", fwd_data, 32'h0);
`endif
    fwd_addr = 32'h44;
    #1;
    check("fwd_miss_be", 32'(fwd_be), 32'h0);
    mem_gnt = 1'b1;
    step();
    step();
    mem_gnt = 1'b0;
    check("final_count", 32'(count), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
